// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage, valid/ready on both sides.
// Optional signed-overflow output OVF is enabled by defining ADDER_OVF_EN.
module pipelined_adder_sub #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CARRY_IN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY_OUT
`ifdef ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH : LO + CHUNK;
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] SPAN = (ONE << HI) - (ONE << LO);
    localparam logic [WIDTH-1:0] MASK = SPAN[WIDTH-1:0];

    logic             v_src;
    logic             c_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] s_next;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] s_q;

    if (k == 0) begin : g_in
      assign v_src = IN_VALID;
      assign a_src = X;
      assign b_src = SUB ? ~Y : Y;
      assign s_src = '0;
      assign c_src = SUB | CARRY_IN;
    end else begin : g_in
      assign v_src = g_st[k-1].v_q;
      assign a_src = g_st[k-1].g_fwd.a_q;
      assign b_src = g_st[k-1].g_fwd.b_q;
      assign s_src = g_st[k-1].s_q;
      assign c_src = g_st[k-1].c_q;
    end

    // Full-width add of the masked chunk; the chunk carry lands exactly at bit HI.
    assign t      = {1'b0, a_src & MASK} + {1'b0, b_src & MASK} + ({{WIDTH{1'b0}}, c_src} << LO);
    assign s_next = (s_src & ~MASK) | (t[WIDTH-1:0] & MASK);

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (!stall) begin
        v_q <= v_src;
        s_q <= s_next;
        c_q <= |(t >> HI);
      end
    end

    // Operands only need to travel on to stages that still have chunks to add.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_src;
          b_q <= b_src;
        end
      end
    end
  end

  assign OUT_VALID = g_st[STAGES-1].v_q;
  assign SUM       = g_st[STAGES-1].s_q;
  assign CARRY_OUT = g_st[STAGES-1].c_q;
  assign stall     = OUT_VALID && !OUT_READY;
  assign IN_READY  = !stall;

`ifdef ADDER_OVF_EN
  logic ovf_next;

  assign ovf_next = (g_st[STAGES-1].a_src[WIDTH-1] == g_st[STAGES-1].b_src[WIDTH-1]) &&
                    (g_st[STAGES-1].s_next[WIDTH-1] != g_st[STAGES-1].a_src[WIDTH-1]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF <= 1'b0;
    end else if (!stall) begin
      OVF <= ovf_next;
    end
  end
`endif

endmodule
